// File: rtl/axi4lite_slave_ram.sv
// AXI4-Lite slave RAM: independent read/write paths, AW/W in any order, per-byte strobes,
// fixed read latency of 1+RD_WAIT cycles and SLVERR (no write, zero data) outside the window.
module axi4lite_slave_ram #(
  parameter int                 ADDRESS    = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 MEM_DEPTH  = 1024,
  parameter logic [ADDRESS-1:0] BASE_ADDR  = '0,
  parameter int                 RD_WAIT    = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);
  localparam int NSTRB = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(NSTRB);
  localparam int IDXW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  function automatic logic addr_err(input logic [ADDRESS-1:0] addr);
    logic [ADDRESS-1:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || ((off >> (OFFW + IDXW)) != '0);
  endfunction

  function automatic logic [IDXW-1:0] addr_idx(input logic [ADDRESS-1:0] addr);
    logic [ADDRESS-1:0] off;
    off = addr - BASE_ADDR;
    return IDXW'(off >> OFFW);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  rdy_q;
  logic                  aw_held_q, aw_held_d, aw_err_q, aw_err_d;
  logic [IDXW-1:0]       aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NSTRB-1:0]      w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, commit, wr_err;
  logic [IDXW-1:0]       wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NSTRB-1:0]      wr_strb;

  r_state_e              r_state_q, r_state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IDXW-1:0]       ar_idx_q, ar_idx_d, r_idx;
  logic                  ar_err_q, ar_err_d, r_err, r_load, ar_hs;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  // rdy_q keeps every ready low while reset is held and for no longer than one edge after.
  assign S_AWREADY = rdy_q && !aw_held_q && !bvalid_q;
  assign S_WREADY  = rdy_q && !w_held_q && !bvalid_q;
  assign S_ARREADY = rdy_q && (r_state_q == R_IDLE);
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = (r_state_q == R_DATA);
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

  assign aw_hs   = S_AWVALID && S_AWREADY;
  assign w_hs    = S_WVALID && S_WREADY;
  assign ar_hs   = S_ARVALID && S_ARREADY;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_idx  = aw_held_q ? aw_idx_q : addr_idx(S_AWADDR);
  assign wr_err  = aw_held_q ? aw_err_q : addr_err(S_AWADDR);
  assign wr_data = w_held_q ? w_data_q : S_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : S_WSTRB;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (bvalid_q && S_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? 2'b10 : 2'b00;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = wr_idx;
        aw_err_d  = wr_err;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = S_WDATA;
        w_strb_d = S_WSTRB;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    ar_idx_d  = ar_idx_q;
    ar_err_d  = ar_err_q;
    r_load    = 1'b0;
    r_idx     = ar_idx_q;
    r_err     = ar_err_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        ar_idx_d = addr_idx(S_ARADDR);
        ar_err_d = addr_err(S_ARADDR);
        if (RD_WAIT == 0) begin
          r_state_d = R_DATA;
          r_load    = 1'b1;
          r_idx     = ar_idx_d;
          r_err     = ar_err_d;
        end else begin
          r_state_d = R_WAIT;
          cnt_d     = 3'(RD_WAIT);
        end
      end
      R_WAIT: begin
        if (cnt_q <= 3'd1) begin
          r_state_d = R_DATA;
          r_load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      R_DATA: if (S_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    // Sampling through the array before this edge's write lands gives old data on a collision.
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (r_load) begin
      rdata_d = r_err ? '0 : mem[r_idx];
      rresp_d = r_err ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
      ar_idx_q  <= '0;
      ar_err_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rdy_q     <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
      ar_idx_q  <= ar_idx_d;
      ar_err_q  <= ar_err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (commit && !wr_err) begin
      for (int b = 0; b < NSTRB; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_ram.sv
// Bench for axi4lite_slave_ram: two instances (zero-wait at base 0, RD_WAIT=3 at base 0x1000),
// directed scenarios plus random traffic checked against a word-array model.
module tb_axi4lite_slave_ram;
  logic        aclk, areset;
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [3:0]  wstrb [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2];
  logic        bvalid [2], bready [2], arvalid [2], arready [2];
  logic        rvalid [2], rready [2];
  logic [1:0]  bresp [2], rresp [2];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model [int];

  axi4lite_slave_ram dut0 (
    .ACLK(aclk), .ARESET(areset),
    .S_AWADDR(awaddr[0]), .S_AWVALID(awvalid[0]), .S_AWREADY(awready[0]),
    .S_WDATA(wdata[0]), .S_WSTRB(wstrb[0]), .S_WVALID(wvalid[0]), .S_WREADY(wready[0]),
    .S_BRESP(bresp[0]), .S_BVALID(bvalid[0]), .S_BREADY(bready[0]),
    .S_ARADDR(araddr[0]), .S_ARVALID(arvalid[0]), .S_ARREADY(arready[0]),
    .S_RDATA(rdata[0]), .S_RRESP(rresp[0]), .S_RVALID(rvalid[0]), .S_RREADY(rready[0])
  );

  axi4lite_slave_ram #(.MEM_DEPTH(64), .BASE_ADDR(32'h1000), .RD_WAIT(3)) dut1 (
    .ACLK(aclk), .ARESET(areset),
    .S_AWADDR(awaddr[1]), .S_AWVALID(awvalid[1]), .S_AWREADY(awready[1]),
    .S_WDATA(wdata[1]), .S_WSTRB(wstrb[1]), .S_WVALID(wvalid[1]), .S_WREADY(wready[1]),
    .S_BRESP(bresp[1]), .S_BVALID(bvalid[1]), .S_BREADY(bready[1]),
    .S_ARADDR(araddr[1]), .S_ARVALID(arvalid[1]), .S_ARREADY(arready[1]),
    .S_RDATA(rdata[1]), .S_RRESP(rresp[1]), .S_RVALID(rvalid[1]), .S_RREADY(rready[1])
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h1000;
  endfunction
  function automatic int depth_of(input int d);
    return (d == 0) ? 1024 : 64;
  endfunction
  function automatic int rdw_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction
  function automatic bit ref_err(input int d, input logic [31:0] a);
    if (a < base_of(d)) return 1'b1;
    return ((a - base_of(d)) >> 2) >= 32'(depth_of(d));
  endfunction
  function automatic int ref_key(input int d, input logic [31:0] a);
    return d * 4096 + int'((a - base_of(d)) >> 2);
  endfunction
  function automatic void ref_write(input int d, input logic [31:0] a, input logic [31:0] v,
                                    input logic [3:0] s);
    logic [31:0] w;
    int k;
    if (ref_err(d, a)) return;
    k = ref_key(d, a);
    w = model.exists(k) ? model[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = v[8*b +: 8];
    model[k] = w;
  endfunction

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  // lead > 0: W is offered lead cycles before AW; lead < 0: AW leads by -lead cycles.
  task automatic write_txn(input int d, input logic [31:0] a, input logic [31:0] v,
                           input logic [3:0] s, input int lead,
                           output logic [1:0] resp, output int blat, output bit ok);
    bit aw_done, w_done, aw_hs, w_hs;
    int t;
    aw_done = 0; w_done = 0; t = 0; ok = 1;
    awaddr[d] = a; wdata[d] = v; wstrb[d] = s; bready[d] = 1'b0;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid[d] = !aw_done && (t >= ((lead < 0) ? 0 : lead));
      wvalid[d]  = !w_done && (t >= ((lead > 0) ? 0 : -lead));
      aw_hs = awvalid[d] && awready[d];
      w_hs  = wvalid[d] && wready[d];
      step();
      t++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    if (!(aw_done && w_done)) ok = 0;
    blat = 0;
    while (bvalid[d] !== 1'b1 && blat < 20) begin step(); blat++; end
    if (bvalid[d] !== 1'b1) ok = 0;
    resp = bresp[d];
    bready[d] = 1'b1; step(); bready[d] = 1'b0;
    if (bvalid[d] !== 1'b0) ok = 0;
  endtask

  task automatic read_txn(input int d, input logic [31:0] a, input int hold,
                          output logic [31:0] v, output logic [1:0] resp,
                          output int lat, output bit stable, output bit ok);
    int t;
    ok = 1; stable = 1; t = 0;
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b0;
    while (arready[d] !== 1'b1 && t < 20) begin step(); t++; end
    if (arready[d] !== 1'b1) ok = 0;
    step();
    arvalid[d] = 1'b0;
    lat = 1;
    while (rvalid[d] !== 1'b1 && lat < 20) begin step(); lat++; end
    if (rvalid[d] !== 1'b1) ok = 0;
    v = rdata[d]; resp = rresp[d];
    for (int i = 0; i < hold; i++) begin
      step();
      if (rvalid[d] !== 1'b1 || rdata[d] !== v || rresp[d] !== resp) stable = 0;
    end
    rready[d] = 1'b1; step(); rready[d] = 1'b0;
    if (rvalid[d] !== 1'b0) ok = 0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({awready[d], wready[d], arready[d], bvalid[d], rvalid[d]} !== 5'b0)
        $display("FAIL reset_ctl d%0d: got %b want 00000", d,
                 {awready[d], wready[d], arready[d], bvalid[d], rvalid[d]});
      else n_pass++;
      n_checks++;
      if (rdata[d] !== 32'h0 || rresp[d] !== 2'b00 || bresp[d] !== 2'b00)
        $display("FAIL reset_data d%0d: got %h/%b/%b want 0/00/00", d, rdata[d], rresp[d], bresp[d]);
      else n_pass++;
    end
    areset = 1'b0;
    #1;
    n_checks++;
    if (arready[0] !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", arready[0]);
    else n_pass++;
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({awready[d], wready[d], arready[d]} !== 3'b111)
        $display("FAIL ready_after_reset d%0d: got %b want 111", d, {awready[d], wready[d], arready[d]});
      else n_pass++;
    end
  endtask

  task automatic test_write_read;
    logic [31:0] v; logic [1:0] resp; int blat, lat; bit ok, stable;
    write_txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, resp, blat, ok);
    ref_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if (!ok || resp !== 2'b00 || blat !== 0)
      $display("FAIL wr_basic: got ok=%0d resp=%b blat=%0d want 1 00 0", ok, resp, blat);
    else n_pass++;
    read_txn(0, 32'h10, 0, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || v !== 32'hDEADBEEF || resp !== 2'b00 || lat !== 1)
      $display("FAIL rd_basic: got ok=%0d %h %b lat=%0d want 1 deadbeef 00 1", ok, v, resp, lat);
    else n_pass++;
  endtask

  task automatic test_strobes;
    logic [31:0] v; logic [1:0] resp; int blat, lat; bit ok, stable;
    write_txn(0, 32'h10, 32'h11223344, 4'b0101, 0, resp, blat, ok);
    ref_write(0, 32'h10, 32'h11223344, 4'b0101);
    read_txn(0, 32'h10, 0, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || v !== 32'hDE22BE44) $display("FAIL strobe_0101: got %h want de22be44", v);
    else n_pass++;
    write_txn(0, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, resp, blat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00) $display("FAIL strobe_zero_resp: got ok=%0d resp=%b want 1 00", ok, resp);
    else n_pass++;
    read_txn(0, 32'h13, 0, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || v !== 32'hDE22BE44) $display("FAIL strobe_zero_noop: got %h want de22be44", v);
    else n_pass++;
  endtask

  task automatic test_ordering;
    logic [31:0] v, a, dv; logic [1:0] resp; int lat; bit ok, stable;
    for (int j = 0; j < 2; j++) begin
      a = 32'h20 + 32'(4 * j);
      dv = (j == 0) ? 32'h12345678 : 32'h9ABCDEF0;
      awaddr[0] = a; wdata[0] = dv; wstrb[0] = 4'hF; bready[0] = 1'b0;
      if (j == 0) wvalid[0] = 1'b1; else awvalid[0] = 1'b1;
      step();
      wvalid[0] = 1'b0; awvalid[0] = 1'b0;
      n_checks++;
      if (((j == 0) ? wready[0] : awready[0]) !== 1'b0)
        $display("FAIL order%0d_first_held: ready got 1 want 0", j);
      else n_pass++;
      step(); step();
      n_checks++;
      if (bvalid[0] !== 1'b0) $display("FAIL order%0d_early_b: got %b want 0", j, bvalid[0]);
      else n_pass++;
      if (j == 0) awvalid[0] = 1'b1; else wvalid[0] = 1'b1;
      step();
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      n_checks++;
      if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b00 || awready[0] !== 1'b0 || wready[0] !== 1'b0)
        $display("FAIL order%0d_commit: got bv=%b br=%b awr=%b wr=%b want 1 00 0 0",
                 j, bvalid[0], bresp[0], awready[0], wready[0]);
      else n_pass++;
      step();
      n_checks++;
      if (bvalid[0] !== 1'b1) $display("FAIL order%0d_b_hold: got %b want 1", j, bvalid[0]);
      else n_pass++;
      bready[0] = 1'b1; step(); bready[0] = 1'b0;
      step();
      n_checks++;
      if (bvalid[0] !== 1'b0 || awready[0] !== 1'b1 || wready[0] !== 1'b1)
        $display("FAIL order%0d_b_done: got bv=%b awr=%b wr=%b want 0 1 1", j, bvalid[0], awready[0], wready[0]);
      else n_pass++;
      ref_write(0, a, dv, 4'hF);
      read_txn(0, a, 0, v, resp, lat, stable, ok);
      n_checks++;
      if (!ok || v !== dv) $display("FAIL order%0d_data: got %h want %h", j, v, dv);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure_error;
    logic [31:0] v; logic [1:0] resp; int blat, lat; bit ok, stable;
    write_txn(1, 32'h1004, 32'hCAFEF00D, 4'hF, 0, resp, blat, ok);
    ref_write(1, 32'h1004, 32'hCAFEF00D, 4'hF);
    read_txn(1, 32'h1004, 5, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || lat !== 4 || !stable || v !== 32'hCAFEF00D || resp !== 2'b00)
      $display("FAIL rd_wait3: got ok=%0d lat=%0d stable=%0d %h %b want 1 4 1 cafef00d 00",
               ok, lat, stable, v, resp);
    else n_pass++;
    for (int d = 0; d < 2; d++) begin
      write_txn(d, base_of(d), 32'h55AA55AA, 4'hF, 0, resp, blat, ok);
      ref_write(d, base_of(d), 32'h55AA55AA, 4'hF);
      write_txn(d, base_of(d) + 32'(4 * depth_of(d)), 32'hFFFFFFFF, 4'hF, 0, resp, blat, ok);
      n_checks++;
      if (!ok || resp !== 2'b10) $display("FAIL wr_slverr d%0d: got ok=%0d resp=%b want 1 10", d, ok, resp);
      else n_pass++;
      read_txn(d, base_of(d), 0, v, resp, lat, stable, ok);
      n_checks++;
      if (!ok || v !== 32'h55AA55AA) $display("FAIL slverr_nowrite d%0d: got %h want 55aa55aa", d, v);
      else n_pass++;
      read_txn(d, base_of(d) + 32'(4 * depth_of(d)), 0, v, resp, lat, stable, ok);
      n_checks++;
      if (!ok || v !== 32'h0 || resp !== 2'b10)
        $display("FAIL rd_slverr d%0d: got %h %b want 0 10", d, v, resp);
      else n_pass++;
    end
    read_txn(1, 32'h0FFC, 0, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || v !== 32'h0 || resp !== 2'b10) $display("FAIL rd_below_base: got %h %b want 0 10", v, resp);
    else n_pass++;
  endtask

  task automatic test_collision;
    logic [31:0] v, a; logic [1:0] resp; int blat, lat; bit ok, stable;
    for (int d = 0; d < 2; d++) begin
      a = base_of(d) + 32'h8;
      write_txn(d, a, 32'h0BADF00D, 4'hF, 0, resp, blat, ok);
      ref_write(d, a, 32'h0BADF00D, 4'hF);
      araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b0; bready[d] = 1'b0;
      for (int k = 0; k < rdw_of(d); k++) begin step(); arvalid[d] = 1'b0; end
      awaddr[d] = a; wdata[d] = 32'hA5A5A5A5; wstrb[d] = 4'hF;
      awvalid[d] = 1'b1; wvalid[d] = 1'b1;
      step();
      awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0;
      n_checks++;
      if (bvalid[d] !== 1'b1 || rvalid[d] !== 1'b1 || rdata[d] !== 32'h0BADF00D)
        $display("FAIL collision_old d%0d: got bv=%b rv=%b %h want 1 1 0badf00d", d, bvalid[d], rvalid[d], rdata[d]);
      else n_pass++;
      rready[d] = 1'b1; bready[d] = 1'b1; step(); rready[d] = 1'b0; bready[d] = 1'b0;
      ref_write(d, a, 32'hA5A5A5A5, 4'hF);
      read_txn(d, a, 0, v, resp, lat, stable, ok);
      n_checks++;
      if (!ok || v !== 32'hA5A5A5A5) $display("FAIL collision_new d%0d: got %h want a5a5a5a5", d, v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] v; logic [1:0] resp; int lat; bit ok, stable;
    wdata[0] = 32'h0; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    araddr[0] = 32'h10; arvalid[0] = 1'b1; rready[0] = 1'b0;
    step();
    wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    n_checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== model[ref_key(0, 32'h10)])
      $display("FAIL midread_pre: got rv=%b %h want 1 %h", rvalid[0], rdata[0], model[ref_key(0, 32'h10)]);
    else n_pass++;
    #1 areset = 1'b1;
    #1;
    n_checks++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0 || arready[0] !== 1'b0)
      $display("FAIL midread_reset: got rv=%b %h arr=%b want 0 0 0", rvalid[0], rdata[0], arready[0]);
    else n_pass++;
    step(); step();
    areset = 1'b0;
    #1;
    n_checks++;
    if (arready[0] !== 1'b0) $display("FAIL midread_release: got %b want 0", arready[0]);
    else n_pass++;
    step();
    n_checks++;
    if (arready[0] !== 1'b1 || rvalid[0] !== 1'b0)
      $display("FAIL midread_after: got arr=%b rv=%b want 1 0", arready[0], rvalid[0]);
    else n_pass++;
    // the W captured before reset must be gone: a lone AW may not commit
    awaddr[0] = 32'h10; awvalid[0] = 1'b1; bready[0] = 1'b0;
    step();
    awvalid[0] = 1'b0;
    step();
    n_checks++;
    if (bvalid[0] !== 1'b0) $display("FAIL aborted_w_commit: got %b want 0", bvalid[0]);
    else n_pass++;
    read_txn(0, 32'h10, 0, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || v !== model[ref_key(0, 32'h10)])
      $display("FAIL aborted_w_data: got %h want %h", v, model[ref_key(0, 32'h10)]);
    else n_pass++;
    wdata[0] = 32'h77777777; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    step();
    wvalid[0] = 1'b0;
    n_checks++;
    if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b00) $display("FAIL held_aw_commit: got %b %b want 1 00", bvalid[0], bresp[0]);
    else n_pass++;
    bready[0] = 1'b1; step(); bready[0] = 1'b0;
    ref_write(0, 32'h10, 32'h77777777, 4'hF);
    read_txn(0, 32'h10, 0, v, resp, lat, stable, ok);
    n_checks++;
    if (!ok || v !== 32'h77777777) $display("FAIL held_aw_data: got %h want 77777777", v);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] a, v, exp_v; logic [3:0] s; logic [1:0] resp, exp_r;
    int d, blat, lat, lead; bit ok, stable;
    for (int d0 = 0; d0 < 2; d0++) begin
      for (int i = 0; i < 8; i++) begin
        a = base_of(d0) + 32'(4 * i);
        v = $urandom;
        write_txn(d0, a, v, 4'hF, 0, resp, blat, ok);
        ref_write(d0, a, v, 4'hF);
        n_checks++;
        if (!ok || resp !== 2'b00) $display("FAIL prefill d%0d i%0d: got ok=%0d resp=%b want 1 00", d0, i, ok, resp);
        else n_pass++;
      end
    end
    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        if (d == 1 && $urandom_range(0, 1) == 0) a = base_of(d) - 32'h4;
        else a = base_of(d) + 32'(4 * depth_of(d)) + 32'(4 * $urandom_range(0, 3));
      end else begin
        a = base_of(d) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      end
      exp_r = ref_err(d, a) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom;
        s = 4'($urandom_range(0, 15));
        lead = int'($urandom_range(0, 4)) - 2;
        write_txn(d, a, v, s, lead, resp, blat, ok);
        ref_write(d, a, v, s);
        n_checks++;
        if (!ok || resp !== exp_r)
          $display("FAIL rnd_wr n%0d d%0d a=%h: got ok=%0d resp=%b want 1 %b", n, d, a, ok, resp, exp_r);
        else n_pass++;
      end else begin
        read_txn(d, a, int'($urandom_range(0, 2)), v, resp, lat, stable, ok);
        exp_v = ref_err(d, a) ? 32'h0 : model[ref_key(d, a)];
        n_checks++;
        if (!ok || !stable || lat !== 1 + rdw_of(d))
          $display("FAIL rnd_rd_timing n%0d d%0d: got ok=%0d stable=%0d lat=%0d want 1 1 %0d",
                   n, d, ok, stable, lat, 1 + rdw_of(d));
        else n_pass++;
        n_checks++;
        if (v !== exp_v || resp !== exp_r)
          $display("FAIL rnd_rd_data n%0d d%0d a=%h: got %h %b want %h %b", n, d, a, v, resp, exp_v, exp_r);
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0; wvalid[d] = 1'b0;
      bready[d] = 1'b0; araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
    end
    areset = 1'b1;
    test_reset();
    test_write_read();
    test_strobes();
    test_ordering();
    test_backpressure_error();
    test_collision();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
